// File: rtl/instr_mem_pkg.sv
// Shared types and default constants for the loadable instruction memory.
// Contents: loader state encoding, default word/address widths, default NOP word.
// Imported by the interface, the storage array and the top level.
package instr_mem_pkg;

   localparam int INSTR_W  = 9;    // default instruction word width
   localparam int INSTR_AW = 12;   // default address width (depth = 2**INSTR_AW)

   // Word returned for out-of-range fetches or fetches made outside RUN.
   localparam logic [INSTR_W-1:0] NOP_WORD = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } ld_state_t;

endpackage

// File: rtl/instr_mem_ld_if.sv
// Bundle of the load-side and fetch-side signals of the instruction memory.
// Ports: load_start/valid/data/done, load_busy, prog_len, prog_ctr,
//        fetch_req/stall, mach_code, fetch_valid, fetch_oob.
// The slave modport is the memory; the master modport is the harness/fetch stage.
interface instr_mem_ld_if
   import instr_mem_pkg::*;
#(
   parameter int D = INSTR_AW,
   parameter int W = INSTR_W
);

   // load side
   logic         load_start;
   logic         load_valid;
   logic [W-1:0] load_data;
   logic         load_done;
   logic         load_busy;
   logic [D:0]   prog_len;

   // fetch side
   logic [D-1:0] prog_ctr;
   logic         fetch_req;
   logic         fetch_stall;
   logic [W-1:0] mach_code;
   logic         fetch_valid;
   logic         fetch_oob;

   modport master (
      output load_start, load_valid, load_data, load_done,
      output prog_ctr, fetch_req, fetch_stall,
      input  load_busy, prog_len, mach_code, fetch_valid, fetch_oob
   );

   modport slave (
      input  load_start, load_valid, load_data, load_done,
      input  prog_ctr, fetch_req, fetch_stall,
      output load_busy, prog_len, mach_code, fetch_valid, fetch_oob
   );

endinterface

// File: rtl/instr_mem_array.sv
// Storage array: one synchronous write port, one registered read port with enable/hold.
// Ports: clk, reset, wr_en/wr_addr/wr_data, rd_en/rd_nop/rd_addr -> rd_data (1-cycle latency).
// rd_en low holds rd_data; rd_nop substitutes NOP_VAL instead of reading the array.
module instr_mem_array
   import instr_mem_pkg::*;
#(
   parameter int D = INSTR_AW,
   parameter int W = INSTR_W,
   parameter logic [W-1:0] NOP_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_en,
   input  logic [D-1:0] wr_addr,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   input  logic         rd_nop,
   input  logic [D-1:0] rd_addr,
   output logic [W-1:0] rd_data
);

   // Array has no reset so it can map onto a RAM macro.
   logic [W-1:0] core [2**D];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         core[wr_addr] <= wr_data;
      end
   end

   // Output register is reset so the fetch port comes up showing NOP_VAL.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data <= NOP_VAL;
      end else if (rd_en) begin
         rd_data <= rd_nop ? NOP_VAL : core[rd_addr];
      end
   end

endmodule

// File: rtl/instr_mem_ld.sv
// Loadable instruction memory: loader FSM, write pointer, program length and fetch bounds check.
// Ports: clk, reset (async, active-high), bus (instr_mem_ld_if.slave). Fetch latency is 1 cycle.
// fetch_stall holds mach_code/fetch_valid/fetch_oob; words beyond 2**D in one load are dropped.
module instr_mem_ld #(
   parameter int D = instr_mem_pkg::INSTR_AW,
   parameter int W = instr_mem_pkg::INSTR_W,
   parameter logic [W-1:0] NOP_WORD = W'(instr_mem_pkg::NOP_WORD)
) (
   input  logic           clk,
   input  logic           reset,
   instr_mem_ld_if.slave  bus
);

   import instr_mem_pkg::*;

   ld_state_t    state;
   logic [D:0]   wr_ptr;      // one bit wider than the address so "full" is representable
   logic [D:0]   prog_len_r;
   logic         fetch_valid_r;
   logic         fetch_oob_r;
   logic [W-1:0] rd_data;

   logic         wr_fire;
   logic         wr_en;
   logic [D-1:0] wr_addr;
   logic         in_range;
   logic         rd_en;

   // Ordinary in-LOAD write; a load_start cycle is handled separately since it
   // rewinds the pointer and any accompanying word lands at address 0.
   assign wr_fire = (state == LOAD) && bus.load_valid && !bus.load_start && !wr_ptr[D];
   assign wr_en   = (bus.load_start && bus.load_valid) || wr_fire;
   assign wr_addr = bus.load_start ? '0 : wr_ptr[D-1:0];

   // Only RUN with an address below the committed length reads the array;
   // this also keeps fetches away from words being written during LOAD.
   assign in_range = (state == RUN) && ({1'b0, bus.prog_ctr} < prog_len_r);
   assign rd_en    = bus.fetch_req && !bus.fetch_stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         wr_ptr        <= '0;
         prog_len_r    <= '0;
         fetch_valid_r <= 1'b0;
         fetch_oob_r   <= 1'b0;
      end else begin
         // loader
         if (bus.load_start) begin
            state      <= LOAD;
            wr_ptr     <= bus.load_valid ? (D+1)'(1) : '0;
            prog_len_r <= '0;
         end else if (state == LOAD) begin
            if (wr_fire) begin
               wr_ptr <= wr_ptr + (D+1)'(1);
            end
            if (bus.load_done) begin
               state      <= RUN;
               prog_len_r <= wr_fire ? wr_ptr + (D+1)'(1) : wr_ptr;
            end
         end

         // fetch status; stall freezes both flags
         if (!bus.fetch_stall) begin
            fetch_valid_r <= bus.fetch_req;
            if (bus.fetch_req) begin
               fetch_oob_r <= !in_range;
            end
         end
      end
   end

   instr_mem_array #(
      .D       (D),
      .W       (W),
      .NOP_VAL (NOP_WORD)
   ) u_array (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (bus.load_data),
      .rd_en   (rd_en),
      .rd_nop  (!in_range),
      .rd_addr (bus.prog_ctr),
      .rd_data (rd_data)
   );

   assign bus.load_busy   = (state == LOAD);
   assign bus.prog_len    = prog_len_r;
   assign bus.mach_code   = rd_data;
   assign bus.fetch_valid = fetch_valid_r;
   assign bus.fetch_oob   = fetch_oob_r;

endmodule

// File: tb/tb_instr_mem_ld.sv
// Bench for instr_mem_ld: a D=12 instance checked every cycle against a queue-based
// program model (directed steps then random loads/fetches), plus a D=2 instance for
// load saturation and same-cycle load_valid/load_done cases.
module tb_instr_mem_ld;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instr_mem_ld_if #(.D(12), .W(9)) bus_a ();
   instr_mem_ld_if #(.D(2),  .W(9)) bus_b ();

   instr_mem_ld #(.D(12), .W(9), .NOP_WORD(9'h000)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   instr_mem_ld #(.D(2), .W(9), .NOP_WORD(9'h000)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- program model for instance A ----------------
   // mode: 0 idle, 1 loading, 2 running
   logic [8:0] buf_q[$];      // words collected by the current load
   logic [8:0] img_q[$];      // committed program
   int         m_mode, m_len;
   logic [8:0] m_mach;
   logic       m_valid, m_oob;

   task automatic model_reset();
      m_mode = 0; m_len = 0; m_mach = 9'h000; m_valid = 1'b0; m_oob = 1'b0;
      buf_q.delete();
   endtask

   task automatic cyc_a(input bit st, input bit lv, input logic [8:0] dat, input bit dn,
                        input int pc, input bit req, input bit stall);
      bus_a.load_start = st;  bus_a.load_valid = lv; bus_a.load_data = dat;
      bus_a.load_done = dn;   bus_a.prog_ctr = 12'(pc);
      bus_a.fetch_req = req;  bus_a.fetch_stall = stall;
      // fetch outcome uses the mode/length in force before this edge
      if (!stall) begin
         if (req) begin
            m_valid = 1'b1;
            if (m_mode == 2 && pc < m_len) begin
               m_mach = img_q[pc]; m_oob = 1'b0;
            end else begin
               m_mach = 9'h000;    m_oob = 1'b1;
            end
         end else begin
            m_valid = 1'b0;
         end
      end
      if (st) begin
         buf_q.delete();
         if (lv) buf_q.push_back(dat);
         m_mode = 1; m_len = 0;
      end else if (m_mode == 1) begin
         if (lv && buf_q.size() < 4096) buf_q.push_back(dat);
         if (dn) begin
            img_q = buf_q; m_len = buf_q.size(); m_mode = 2;
         end
      end
      @(posedge clk); #1;
      chk("a_mach",  bus_a.mach_code,   m_mach);
      chk("a_valid", bus_a.fetch_valid, m_valid);
      chk("a_oob",   bus_a.fetch_oob,   m_oob);
      chk("a_busy",  bus_a.load_busy,   m_mode == 1);
      chk("a_len",   bus_a.prog_len,    m_len);
      bus_a.load_start = 0; bus_a.load_valid = 0; bus_a.load_done = 0;
      bus_a.fetch_req = 0;  bus_a.fetch_stall = 0;
   endtask

   task automatic cyc_b(input bit st, input bit lv, input logic [8:0] dat, input bit dn,
                        input int pc, input bit req);
      bus_b.load_start = st; bus_b.load_valid = lv; bus_b.load_data = dat;
      bus_b.load_done = dn;  bus_b.prog_ctr = 2'(pc);
      bus_b.fetch_req = req; bus_b.fetch_stall = 0;
      @(posedge clk); #1;
      bus_b.load_start = 0; bus_b.load_valid = 0; bus_b.load_done = 0; bus_b.fetch_req = 0;
   endtask

   logic [8:0] w4 [4];
   logic [8:0] rw;
   int n;

   initial begin
      w4[0] = 9'h07E; w4[1] = 9'h066; w4[2] = 9'h07A; w4[3] = 9'h1DE;
      bus_a.load_start = 0; bus_a.load_valid = 0; bus_a.load_data = 0; bus_a.load_done = 0;
      bus_a.prog_ctr = 0; bus_a.fetch_req = 0; bus_a.fetch_stall = 0;
      bus_b.load_start = 0; bus_b.load_valid = 0; bus_b.load_data = 0; bus_b.load_done = 0;
      bus_b.prog_ctr = 0; bus_b.fetch_req = 0; bus_b.fetch_stall = 0;
      model_reset();

      // reset values
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_mach",  bus_a.mach_code,   9'h000);
      chk("rst_valid", bus_a.fetch_valid, 1'b0);
      chk("rst_oob",   bus_a.fetch_oob,   1'b0);
      chk("rst_busy",  bus_a.load_busy,   1'b0);
      chk("rst_len",   bus_a.prog_len,    13'd0);
      reset = 1'b0;

      // fetch before any load -> NOP with oob
      cyc_a(0, 0, 0, 0, 0, 1, 0);
      chk("idle_fetch_oob", bus_a.fetch_oob, 1'b1);

      // load four words and fetch them back-to-back
      cyc_a(1, 0, 0, 0, 0, 0, 0);
      chk("load_busy", bus_a.load_busy, 1'b1);
      for (int i = 0; i < 4; i++) cyc_a(0, 1, w4[i], 0, 0, 0, 0);
      cyc_a(0, 0, 0, 1, 0, 0, 0);
      chk("len4", bus_a.prog_len, 13'd4);
      for (int i = 0; i < 4; i++) begin
         cyc_a(0, 0, 0, 0, i, 1, 0);
         chk("fetch_word", bus_a.mach_code, w4[i]);
      end
      cyc_a(0, 0, 0, 0, 4, 1, 0);
      chk("fetch4_oob", bus_a.fetch_oob, 1'b1);

      // stall holds the fetched word while prog_ctr moves
      cyc_a(0, 0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         cyc_a(0, 0, 0, 0, 2, 1, 1);
         chk("stall_mach",  bus_a.mach_code,   9'h066);
         chk("stall_valid", bus_a.fetch_valid, 1'b1);
      end
      cyc_a(0, 0, 0, 0, 2, 0, 0);
      chk("unstall_valid", bus_a.fetch_valid, 1'b0);

      // asynchronous reset in the middle of a load
      cyc_a(1, 0, 0, 0, 0, 0, 0);
      cyc_a(0, 1, 9'h111, 0, 0, 1, 0);
      cyc_a(0, 1, 9'h122, 0, 0, 1, 0);
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk("arst_busy",  bus_a.load_busy,   1'b0);
      chk("arst_len",   bus_a.prog_len,    13'd0);
      chk("arst_valid", bus_a.fetch_valid, 1'b0);
      chk("arst_oob",   bus_a.fetch_oob,   1'b0);
      chk("arst_mach",  bus_a.mach_code,   9'h000);
      @(negedge clk);
      reset = 1'b0;
      cyc_a(0, 0, 0, 0, 0, 1, 0);
      chk("post_rst_oob", bus_a.fetch_oob, 1'b1);
      cyc_a(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc_a(0, 1, 9'(9'h0A0 + i), 0, 0, 0, 0);
      cyc_a(0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc_a(0, 0, 0, 0, i, 1, 0);

      // load_start with a word while in RUN
      cyc_a(1, 1, 9'h1FF, 0, 0, 0, 0);
      chk("restart_busy", bus_a.load_busy, 1'b1);
      cyc_a(0, 0, 0, 0, 0, 1, 0);
      chk("load_fetch_oob", bus_a.fetch_oob, 1'b1);
      cyc_a(0, 0, 0, 1, 0, 0, 0);
      chk("restart_len", bus_a.prog_len, 13'd1);
      cyc_a(0, 0, 0, 0, 0, 1, 0);
      chk("restart_word", bus_a.mach_code, 9'h1FF);
      chk("restart_oob",  bus_a.fetch_oob, 1'b0);

      // random loads and fetches against the model
      for (int r = 0; r < 8; r++) begin
         n = int'($urandom_range(0, 20));
         cyc_a(1, 1'($urandom_range(0, 1)), 9'($urandom), 0, 0, 0, 0);
         for (int k = 0; k < n; k++) begin
            cyc_a(0, $urandom_range(0, 3) != 0, 9'($urandom), 0,
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
         end
         cyc_a(0, 1'($urandom_range(0, 1)), 9'($urandom), 1, 0, 0, 0);
         for (int k = 0; k < 30; k++) begin
            cyc_a(0, 0, 0, 0, int'($urandom_range(0, n + 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
         end
      end

      // D=2 instance: saturation drops the fifth word
      cyc_b(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc_b(0, 1, 9'(9'h011 * (i + 1)), 0, 0, 0);
      cyc_b(0, 0, 0, 1, 0, 0);
      chk("b_full_len", bus_b.prog_len, 3'd4);
      cyc_b(0, 0, 0, 0, 0, 1);
      chk("b_addr0", bus_b.mach_code, 9'h011);
      chk("b_addr0_oob", bus_b.fetch_oob, 1'b0);
      cyc_b(0, 0, 0, 0, 3, 1);
      chk("b_addr3", bus_b.mach_code, 9'h044);

      // word arriving with load_done is counted
      cyc_b(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) cyc_b(0, 1, 9'(9'h0A1 + i), 0, 0, 0);
      rw = 9'($urandom);
      cyc_b(0, 1, rw, 1, 0, 0);
      chk("b_done_len", bus_b.prog_len, 3'd3);
      cyc_b(0, 0, 0, 0, 2, 1);
      chk("b_done_word", bus_b.mach_code, rw);
      cyc_b(0, 0, 0, 0, 3, 1);
      chk("b_beyond_oob",  bus_b.fetch_oob, 1'b1);
      chk("b_beyond_mach", bus_b.mach_code, 9'h000);

      // full array plus a word with load_done: the extra word is dropped
      cyc_b(1, 1, 9'h0C0, 0, 0, 0);
      for (int i = 1; i < 4; i++) cyc_b(0, 1, 9'(9'h0C0 + i), 0, 0, 0);
      cyc_b(0, 1, 9'h1EE, 1, 0, 0);
      chk("b_full_done_len", bus_b.prog_len, 3'd4);
      cyc_b(0, 0, 0, 0, 0, 1);
      chk("b_full_addr0", bus_b.mach_code, 9'h0C0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
